pacman_irq_ctrl: RTL and testbench

Interrupt controller between the Pac-Man video timing and the `tv80_core` CPU. It latches the IM2 vector byte written to an I/O port and the interrupt-enable bit written to a memory-mapped register. It turns each VBLANK rising edge into a held `int_n` request and drives the vector onto the CPU data-in mux during the interrupt-acknowledge cycle. It sits on the CPU bus beside the address decoder and observes the core's `m1_n`, `iorq`, `write`, `A` and `dout` outputs directly.

---
 rtl/pacman_bus_pkg.sv | 40 ++++
 rtl/sync_rise.sv | 62 ++++++
 rtl/pacman_irq_ctrl.sv | 146 ++++++++++++++
 tb/tb_pacman_irq_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_bus_pkg.sv
// pacman_bus_pkg: shared types and decode helpers for the Pac-Man CPU bus.
//   irq_state_t  - interrupt controller state encoding (IDLE, PEND, ACK)
//   PORT_IRQ_VEC - default I/O port holding the IM2 vector byte
//   ADDR_IRQ_EN  - default memory address of the interrupt-enable register
//   dec_io_wr / dec_mem_wr / dec_ack - strobe decode from raw tv80 outputs
package pacman_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } irq_state_t;

    localparam logic [7:0]  PORT_IRQ_VEC = 8'h00;
    localparam logic [15:0] ADDR_IRQ_EN  = 16'h5000;

    // I/O write outside an M1 cycle to the given port (low address byte only).
    function automatic logic dec_io_wr(input logic       write,
                                       input logic       iorq,
                                       input logic       m1_n,
                                       input logic [7:0] a_lo,
                                       input logic [7:0] port);
        return write & iorq & m1_n & (a_lo == port);
    endfunction

    // Memory write (no IORQ) to the given full 16-bit address.
    function automatic logic dec_mem_wr(input logic        write,
                                        input logic        iorq,
                                        input logic [15:0] a,
                                        input logic [15:0] addr);
        return write & ~iorq & (a == addr);
    endfunction

    // Interrupt acknowledge: IORQ asserted during an M1 cycle.
    function automatic logic dec_ack(input logic m1_n,
                                     input logic iorq);
        return ~m1_n & iorq;
    endfunction

endpackage

// File: rtl/sync_rise.sv
// sync_rise: optional N-flop synchronizer followed by a rising-edge detector.
//   DEPTH   - synchronizer flops before the edge detector (0 = input already
//             in the clk domain)
//   clk     - clock
//   reset_n - asynchronous active-low reset, clears all flops to 0
//   d       - input level
//   rise    - high for the cycle in which the (synchronized) level is 1 and
//             its one-cycle-delayed copy is 0
module sync_rise #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic sync_lvl;

    generate
        if (DEPTH == 0) begin : g_direct
            assign sync_lvl = d;
        end else begin : g_sync
            logic [DEPTH-1:0] sync_q;
            logic [DEPTH-1:0] sync_d;

            always_comb begin
                sync_d    = sync_q;
                sync_d[0] = d;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign sync_lvl = sync_q[DEPTH-1];
        end
    endgenerate

    logic prev_q;
    logic prev_d;

    assign prev_d = sync_lvl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = sync_lvl & ~prev_q;

endmodule

// File: rtl/pacman_irq_ctrl.sv
// pacman_irq_ctrl: VBLANK interrupt controller for the tv80 core (IM2).
//   VEC_PORT    - I/O port (A[7:0]) that latches the vector byte
//   IRQ_EN_ADDR - memory address of the enable register (bit 0)
//   clk, reset_n          - clock, asynchronous active-low reset
//   vblank                - raw VBLANK level, asynchronous to clk
//   m1_n, iorq, write, A, dout - tv80 bus outputs observed directly
//   int_n   - registered interrupt request to the core (active low)
//   vec_oe  - registered select of vec onto the core data-in mux
//   vec     - latched IM2 vector byte
//   irq_en  - enable register value
//   pending - request raised or being acknowledged
module pacman_irq_ctrl
    import pacman_bus_pkg::*;
#(
    parameter logic [7:0]  VEC_PORT    = PORT_IRQ_VEC,
    parameter logic [15:0] IRQ_EN_ADDR = ADDR_IRQ_EN
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vblank,
    input  logic        m1_n,
    input  logic        iorq,
    input  logic        write,
    input  logic [15:0] A,
    input  logic [7:0]  dout,
    output logic        int_n,
    output logic        vec_oe,
    output logic [7:0]  vec,
    output logic        irq_en,
    output logic        pending
);

    logic io_wr, mem_wr, ack;
    logic io_wr_rise, mem_wr_rise, ack_rise, vb_rise;
    logic disable_wr;

    assign io_wr  = dec_io_wr(write, iorq, m1_n, A[7:0], VEC_PORT);
    assign mem_wr = dec_mem_wr(write, iorq, A, IRQ_EN_ADDR);
    assign ack    = dec_ack(m1_n, iorq);

    sync_rise #(.DEPTH(0)) u_io_wr_rise (
        .clk(clk), .reset_n(reset_n), .d(io_wr), .rise(io_wr_rise)
    );
    sync_rise #(.DEPTH(0)) u_mem_wr_rise (
        .clk(clk), .reset_n(reset_n), .d(mem_wr), .rise(mem_wr_rise)
    );
    sync_rise #(.DEPTH(0)) u_ack_rise (
        .clk(clk), .reset_n(reset_n), .d(ack), .rise(ack_rise)
    );
    sync_rise #(.DEPTH(2)) u_vb_rise (
        .clk(clk), .reset_n(reset_n), .d(vblank), .rise(vb_rise)
    );

    irq_state_t  state_q, state_d;
    logic [7:0]  vec_q, vec_d;
    logic        irq_en_q, irq_en_d;
    logic        banked_q, banked_d;
    logic        int_n_q, int_n_d;
    logic        vec_oe_q, vec_oe_d;
    logic        pending_q, pending_d;

    assign disable_wr = mem_wr_rise & ~dout[0];

    always_comb begin
        vec_d     = vec_q;
        irq_en_d  = irq_en_q;
        state_d   = state_q;
        banked_d  = banked_q;

        if (io_wr_rise) begin
            vec_d = dout;
        end
        if (mem_wr_rise) begin
            irq_en_d = dout[0];
        end

        // Gating on the post-write enable makes a same-cycle disable win
        // over a VBLANK edge.
        case (state_q)
            IDLE: begin
                if (vb_rise && irq_en_d) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (vb_rise && irq_en_d) begin
                    banked_d = 1'b1;
                end
                if (disable_wr) begin
                    state_d = IDLE;
                end else if (ack_rise) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (vb_rise && irq_en_d) begin
                    banked_d = 1'b1;
                end
                if (!ack) begin
                    state_d  = (banked_d && irq_en_d) ? PEND : IDLE;
                    banked_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!irq_en_d) begin
            banked_d = 1'b0;
        end

        // Outputs are registered from the next state so they carry no
        // combinational path from the bus inputs.
        int_n_d   = (state_d != PEND);
        vec_oe_d  = (state_d == ACK);
        pending_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            irq_en_q  <= 1'b0;
            banked_q  <= 1'b0;
            int_n_q   <= 1'b1;
            vec_oe_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            irq_en_q  <= irq_en_d;
            banked_q  <= banked_d;
            int_n_q   <= int_n_d;
            vec_oe_q  <= vec_oe_d;
            pending_q <= pending_d;
        end
    end

    assign int_n   = int_n_q;
    assign vec_oe  = vec_oe_q;
    assign vec     = vec_q;
    assign irq_en  = irq_en_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_pacman_irq_ctrl.sv
// tb_pacman_irq_ctrl: scoreboard bench for pacman_irq_ctrl. Stimulus pushes
// the expected output snapshot {int_n, vec_oe, pending, irq_en, vec} together
// with the clock count at which it must appear; a monitor pops one entry for
// every observed output change and compares both value and timing.
module tb_pacman_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        vblank = 1'b0;
    logic        m1_n = 1'b1;
    logic        iorq = 1'b0;
    logic        write = 1'b0;
    logic [15:0] A = 16'h0000;
    logic [7:0]  dout = 8'h00;
    logic        int_n, vec_oe, irq_en, pending;
    logic [7:0]  vec;

    pacman_irq_ctrl #(
        .VEC_PORT(8'h00),
        .IRQ_EN_ADDR(16'h5000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .vblank(vblank), .m1_n(m1_n),
        .iorq(iorq), .write(write), .A(A), .dout(dout),
        .int_n(int_n), .vec_oe(vec_oe), .vec(vec), .irq_en(irq_en),
        .pending(pending)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [11:0] snap;
    assign snap = {int_n, vec_oe, pending, irq_en, vec};

    typedef struct {
        int unsigned cyc;
        logic [11:0] outs;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_go = 1'b0;

    localparam logic [11:0] RESET_SNAP = 12'h800;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int unsigned dc, input logic i_n, input logic oe,
                        input logic p, input logic en, input logic [7:0] v);
        exp_t e;
        e.cyc  = cyc + dc;
        e.outs = {i_n, oe, p, en, v};
        exp_q.push_back(e);
    endtask

    task automatic check_direct(input string name, input logic [11:0] got,
                                input logic [11:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic bus_io_wr(input logic [7:0] d);
        write = 1'b1; iorq = 1'b1; m1_n = 1'b1; A = 16'h5000; dout = d;
        tick();
        write = 1'b0; iorq = 1'b0; A = 16'h0000;
    endtask

    task automatic bus_mem_wr(input logic [7:0] d);
        write = 1'b1; iorq = 1'b0; m1_n = 1'b1; A = 16'h5000; dout = d;
        tick();
        write = 1'b0; A = 16'h0000;
    endtask

    task automatic vb_pulse();
        vblank = 1'b1;
        tick(); tick();
        vblank = 1'b0;
        tick(); tick();
    endtask

    task automatic ack_on();
        m1_n = 1'b0; iorq = 1'b1;
    endtask

    task automatic ack_off();
        m1_n = 1'b1; iorq = 1'b0;
    endtask

    // Monitor: one scoreboard pop per observed output change.
    initial begin
        logic [11:0] prev;
        logic [11:0] cur;
        exp_t        e;
        wait (mon_go);
        @(negedge clk);
        prev = snap;
        forever begin
            @(negedge clk);
            cur = snap;
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.outs || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL outputs got=%h at cyc %0d required=%h at cyc %0d",
                                 cur, cyc, e.outs, e.cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        exp_t e;
        #1 reset_n = 1'b0;
        #1 check_direct("reset_state", snap, RESET_SNAP);
        tick(); tick();
        reset_n = 1'b1;
        mon_go  = 1'b1;
        tick(); tick();

        // Vector write, strobe held for two clocks with dout changing: one write only.
        push(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hCF);
        write = 1'b1; iorq = 1'b1; m1_n = 1'b1; A = 16'h5000; dout = 8'hCF;
        tick();
        dout = 8'hAA;
        tick();
        write = 1'b0; iorq = 1'b0; A = 16'h0000;
        tick();
        push(1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hCF);
        bus_mem_wr(8'h01);
        tick();

        // VBLANK -> request 3 clocks later; 3-clock acknowledge.
        push(3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hCF);
        vb_pulse();
        tick();
        push(1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hCF);
        ack_on();
        tick(); tick(); tick();
        push(1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hCF);
        ack_off();
        tick(); tick();

        // Disabled: VBLANK discarded.
        push(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hCF);
        bus_mem_wr(8'h00);
        vb_pulse();
        tick(); tick();

        // Disable while pending drops the request without an ack.
        push(1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hCF);
        bus_mem_wr(8'h01);
        tick();
        push(3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hCF);
        vb_pulse();
        tick();
        push(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hCF);
        bus_mem_wr(8'h00);
        tick(); tick();

        // Two VBLANKs during ACK: one banked request, second lost.
        push(1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hCF);
        bus_mem_wr(8'h01);
        tick();
        push(3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hCF);
        vb_pulse();
        push(1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hCF);
        ack_on();
        tick();
        vb_pulse();
        vb_pulse();
        tick(); tick();
        push(1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hCF);
        ack_off();
        tick();
        repeat (8) tick();
        push(1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hCF);
        ack_on();
        tick(); tick();
        push(1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hCF);
        ack_off();
        repeat (8) tick();

        // Asynchronous reset in the middle of an acknowledge.
        push(1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A);
        bus_io_wr(8'h5A);
        tick();
        push(3, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A);
        vb_pulse();
        push(1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A);
        ack_on();
        tick(); tick();
        push(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        #1 reset_n = 1'b0;
        #1 check_direct("async_reset_mid_ack", snap, RESET_SNAP);
        ack_off();
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() != 0) tick();
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_change required=%h at cyc %0d", e.outs, e.cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
